// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the Fibonacci job scheduler.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

  localparam int unsigned FIB_W     = 32;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned FIB_MAX_N = 47;
  localparam logic [FIB_W-1:0] FIB_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching upward from last_i+1 with wrap.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    idx      = '0;
    if (en_i) begin
      // Scan from lowest to highest priority; the last hit is the nearest requester after last_i.
      for (int unsigned off = N; off >= 1; off--) begin
        idx = IW'((32'(last_i) + off) % N);
        if (req_i[idx]) begin
          gnt_o      = '0;
          gnt_o[idx] = 1'b1;
          gnt_id_o   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/fib_sched.sv
// fib_sched: shares one Fibonacci engine among NUM_REQ requesters, one job at a time.
// Optional issue/wait watchdog built when FIB_SCHED_TIMEOUT_EN is defined.
module fib_sched
  import fib_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned MAX_N   = FIB_MAX_N,
  parameter  int unsigned TIMEOUT = 1023,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*IDX_W-1:0] req_n,
  output logic [NUM_REQ-1:0]       req_rdy,
  output logic [NUM_REQ-1:0]       resp_vld,
  output logic [FIB_W-1:0]         resp_data,
  output logic                     resp_err,
  input  logic [NUM_REQ-1:0]       resp_rdy,
  output logic                     eng_vld_in,
  output logic [IDX_W-1:0]         eng_fib_in,
  input  logic                     eng_rdy_in,
  input  logic                     eng_vld_out,
  input  logic [FIB_W-1:0]         eng_fib_out,
  output logic                     eng_rdy_out,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id
);

  localparam logic [IDX_W-1:0] MAX_N_IDX = IDX_W'(MAX_N);

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d, id_q, id_d;
  logic [IDX_W-1:0] n_q, n_d, sel_n;
  logic [FIB_W-1:0] data_q, data_d;
  logic             arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             timeout_hit;
  logic             stale_q;

  assign arb_en = rst_n && (state_q == IDLE);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (req_vld),
    .last_i  (last_q),
    .en_i    (arb_en),
    .gnt_o   (gnt),
    .gnt_id_o(gnt_id)
  );

  assign req_rdy = gnt;
  assign sel_n   = IDX_W'(req_n >> (gnt_id * IDX_W));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    n_d     = n_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          last_d = gnt_id;
          id_d   = gnt_id;
          n_d    = sel_n;
          if (sel_n > MAX_N_IDX) begin
            data_d  = FIB_SAT;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (eng_rdy_in) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          data_d  = '0;
          state_d = RESP;
        end
      end
      WAIT: begin
        if (eng_vld_out && !stale_q) begin
          data_d  = eng_fib_out;
          state_d = RESP;
        end else if (timeout_hit) begin
          data_d  = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_rdy[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      n_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      n_q     <= n_d;
      data_q  <= data_d;
    end
  end

`ifdef FIB_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, stale_d, timeout_fire;

  assign timeout_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign timeout_fire = timeout_hit &&
                        (((state_q == ISSUE) && !eng_rdy_in) ||
                         ((state_q == WAIT) && !(eng_vld_out && !stale_q)));

  always_comb begin
    cnt_d   = '0;
    err_d   = err_q;
    stale_d = stale_q;
    if (((state_q == ISSUE) || (state_q == WAIT)) && (state_d == state_q))
      cnt_d = cnt_q + 1'b1;
    if ((state_q == IDLE) && (|gnt)) err_d = 1'b0;
    else if (timeout_fire)           err_d = 1'b1;
    // Only a job the engine already accepted can produce a late result worth discarding.
    if (timeout_fire && (state_q == WAIT)) stale_d = 1'b1;
    else if (stale_q && eng_vld_out)       stale_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stale_q <= stale_d;
    end
  end

  assign resp_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign stale_q     = 1'b0;
  assign resp_err    = 1'b0;
`endif

  always_comb begin
    resp_vld = '0;
    if (state_q == RESP) resp_vld[id_q] = 1'b1;
  end

  assign resp_data   = data_q;
  assign eng_vld_in  = (state_q == ISSUE);
  assign eng_fib_in  = n_q;
  assign eng_rdy_out = (state_q == WAIT) || stale_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = id_q;

endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: table-driven, hand-written and randomized checks of fib_sched against a
// requester/engine model built from the round-robin and Fibonacci rules.
module tb_fib_sched;

  localparam int NR = 4;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [3:0]  req_vld;
  logic [31:0] req_n;
  logic [3:0]  req_rdy;
  logic [3:0]  resp_vld;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [3:0]  resp_rdy;
  logic        eng_vld_in;
  logic [7:0]  eng_fib_in;
  logic        eng_rdy_in;
  logic        eng_vld_out;
  logic [31:0] eng_fib_out;
  logic        eng_rdy_out;
  logic        busy;
  logic [1:0]  grant_id;

  always #5 CLK = ~CLK;

  fib_sched #(.NUM_REQ(NR), .MAX_N(47), .TIMEOUT(20)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .req_vld(req_vld), .req_n(req_n), .req_rdy(req_rdy),
    .resp_vld(resp_vld), .resp_data(resp_data), .resp_err(resp_err), .resp_rdy(resp_rdy),
    .eng_vld_in(eng_vld_in), .eng_fib_in(eng_fib_in), .eng_rdy_in(eng_rdy_in),
    .eng_vld_out(eng_vld_out), .eng_fib_out(eng_fib_out), .eng_rdy_out(eng_rdy_out),
    .busy(busy), .grant_id(grant_id)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int          rq;
    logic [7:0]  n;
    int          acc;
    int          ret;
    int          rsp;
    logic [31:0] data;
    int          lat;
  } vec_t;

  function automatic logic [31:0] fib(input int n);
    logic [31:0] a, b, t;
    a = 32'd0;
    b = 32'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // One job: present mask/indices, model the engine with the given delays, hold back the
  // response acceptance rsp cycles, and check grant, latency, data and stability.
  task automatic run(input string tag, input logic [3:0] mask, input logic [31:0] nn,
                     input int acc, input int ret, input int rsp, input int eid,
                     input logic [31:0] edata, input logic eerr, input int elat);
    int lat, icnt, wcnt;
    bit issued;
    logic [7:0] n;
    logic [3:0] oh;
    oh = 4'(1 << eid);
    n  = 8'(nn >> (eid * 8));
    cyc();
    req_vld = mask;
    req_n   = nn;
    #1;
    chk({tag, " accept"}, 32'(req_rdy), 32'(oh));
    lat = 0; icnt = 0; wcnt = 0; issued = 0;
    while (1) begin
      cyc();
      lat++;
      req_vld     = '1;
      eng_rdy_in  = eng_vld_in && (icnt == acc);
      if (eng_vld_in) icnt++;
      eng_vld_out = eng_rdy_out && (wcnt == ret);
      eng_fib_out = eng_vld_out ? fib(int'(n)) : $urandom();
      if (eng_rdy_out) wcnt++;
      #1;
      if (resp_vld != 4'b0 || lat > 60) break;
      chk({tag, " no accept while busy"}, 32'(req_rdy), 32'h0);
      chk({tag, " grant_id"}, 32'(grant_id), 32'(eid));
      if (eng_vld_in) begin
        issued = 1;
        chk({tag, " eng_fib_in"}, 32'(eng_fib_in), 32'(n));
      end
    end
    eng_rdy_in  = 1'b0;
    eng_vld_out = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " engine used"}, 32'(issued), 32'(n <= 8'd47));
    for (int k = 0; k <= rsp; k++) begin
      if (k > 0) begin
        cyc();
        #1;
      end
      chk({tag, " resp_vld"}, 32'(resp_vld), 32'(oh));
      chk({tag, " resp_data"}, resp_data, edata);
      chk({tag, " resp_err"}, 32'(resp_err), 32'(eerr));
      resp_rdy = (k == rsp) ? oh : ~oh;
      if (k == rsp) req_vld = '0;
    end
    cyc();
    resp_rdy = '0;
    #1;
    chk({tag, " idle after resp"}, 32'(busy), 32'h0);
    chk({tag, " resp dropped"}, 32'(resp_vld), 32'h0);
  endtask

  vec_t tbl[8];
  int   last_m;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_vld = '0; req_n = '0; resp_rdy = '0;
    eng_rdy_in = 1'b0; eng_vld_out = 1'b0; eng_fib_out = '0;

    repeat (3) cyc();
    req_vld = '1;
    #1;
    chk("reset req_rdy", 32'(req_rdy), 32'h0);
    chk("reset resp_vld", 32'(resp_vld), 32'h0);
    chk("reset resp_data", resp_data, 32'h0);
    chk("reset resp_err", 32'(resp_err), 32'h0);
    chk("reset eng_vld_in", 32'(eng_vld_in), 32'h0);
    chk("reset eng_rdy_out", 32'(eng_rdy_out), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset grant_id", 32'(grant_id), 32'h0);
    req_vld = '0;
    rst_n   = 1'b1;

    // Contention from reset: all requesters valid, indices 3,5,7,9 -> fib 2,5,13,34.
    run("cont0", 4'hF, 32'h09070503, 0, 0, 0, 0, 32'd2, 1'b0, 3);
    run("cont1", 4'hF, 32'h09070503, 0, 0, 0, 1, 32'd5, 1'b0, 3);
    run("cont2", 4'hF, 32'h09070503, 0, 0, 0, 2, 32'd13, 1'b0, 3);
    run("cont3", 4'hF, 32'h09070503, 0, 0, 0, 3, 32'd34, 1'b0, 3);
    run("cont4", 4'hF, 32'h09070503, 0, 0, 0, 0, 32'd2, 1'b0, 3);
    last_m = 0;

    tbl[0] = '{0, 8'd10,  0, 0, 0, 32'd55,         3};
    tbl[1] = '{2, 8'd48,  0, 0, 0, 32'hFFFF_FFFF,  1};
    tbl[2] = '{2, 8'd47,  0, 0, 0, 32'd2971215073, 3};
    tbl[3] = '{3, 8'd0,   0, 0, 0, 32'd0,          3};
    tbl[4] = '{1, 8'd20,  5, 0, 4, 32'd6765,       8};
    tbl[5] = '{0, 8'd1,   0, 3, 0, 32'd1,          6};
    tbl[6] = '{1, 8'd255, 0, 0, 2, 32'hFFFF_FFFF,  1};
    tbl[7] = '{3, 8'd12,  2, 2, 1, 32'd144,        7};
    for (int i = 0; i < 8; i++) begin
      logic [31:0] nn;
      nn = '0;
      nn[tbl[i].rq*8 +: 8] = tbl[i].n;
      run($sformatf("tbl%0d", i), 4'(1 << tbl[i].rq), nn, tbl[i].acc, tbl[i].ret,
          tbl[i].rsp, tbl[i].rq, tbl[i].data, 1'b0, tbl[i].lat);
      last_m = tbl[i].rq;
    end

    for (int t = 0; t < 40; t++) begin
      logic [3:0]  m;
      logic [31:0] nn, ed;
      logic [7:0]  n;
      int eid, acc, ret, rsp, el;
      m = 4'($urandom_range(1, 15));
      for (int b = 0; b < NR; b++) nn[b*8 +: 8] = 8'($urandom_range(0, 52));
      acc = $urandom_range(0, 3);
      ret = $urandom_range(0, 3);
      rsp = $urandom_range(0, 3);
      eid = -1;
      for (int k = 1; k <= NR; k++)
        if (eid < 0 && m[(last_m + k) % NR]) eid = (last_m + k) % NR;
      n  = 8'(nn >> (eid * 8));
      ed = (n > 8'd47) ? 32'hFFFF_FFFF : fib(int'(n));
      el = (n > 8'd47) ? 1 : 3 + acc + ret;
      run($sformatf("rand%0d", t), m, nn, acc, ret, rsp, eid, ed, 1'b0, el);
      last_m = eid;
    end

`ifdef FIB_SCHED_TIMEOUT_EN
    run("to_issue", 4'b0001, 32'h0000_0004, 1000, 0, 0, 0, 32'h0, 1'b1, 21);
    run("to_wait", 4'b0010, 32'h0000_0600, 0, 1000, 0, 1, 32'h0, 1'b1, 22);
    cyc();
    eng_vld_out = 1'b1;
    eng_fib_out = 32'd8;
    #1;
    chk("stale result acked", 32'(eng_rdy_out), 32'h1);
    cyc();
    eng_vld_out = 1'b0;
    #1;
    chk("stale flag cleared", 32'(eng_rdy_out), 32'h0);
    chk("stale no resp", 32'(resp_vld), 32'h0);
    chk("stale not busy", 32'(busy), 32'h0);
`endif

    // Reset during WAIT, then a late engine result must not produce a response.
    cyc();
    req_vld = 4'b0100;
    req_n   = 32'h0005_0000;
    #1;
    chk("rst accept", 32'(req_rdy), 32'h4);
    cyc();
    req_vld    = '0;
    eng_rdy_in = 1'b1;
    #1;
    chk("rst issue", 32'(eng_vld_in), 32'h1);
    cyc();
    eng_rdy_in = 1'b0;
    rst_n      = 1'b0;
    req_vld    = '1;
    #1;
    chk("rst in wait", 32'(eng_rdy_out), 32'h1);
    cyc();
    #1;
    chk("rst req_rdy gated", 32'(req_rdy), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    cyc();
    rst_n       = 1'b1;
    req_vld     = '0;
    eng_vld_out = 1'b1;
    eng_fib_out = 32'd5;
    #1;
    chk("late result not taken", 32'(eng_rdy_out), 32'h0);
    repeat (2) begin
      cyc();
      #1;
      chk("late result no resp", 32'(resp_vld), 32'h0);
      chk("late result idle", 32'(busy), 32'h0);
    end
    eng_vld_out = 1'b0;
    run("post reset", 4'hF, 32'h0403_0201, 0, 0, 0, 0, 32'd1, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
